// File: rtl/ether_gmii_port.sv
// ether_gmii_port
//   GMII front end between the PCS/PMA GMII pins and the single-clock
//   abstract Ethernet byte interface used by the aggregator.
//   - Rx: one register stage. Frames in flight at reset release are dropped.
//     A frame is truncated from the first byte that carries gmii_rx_er.
//   - Tx: TX_PIPE register stages. The last stage is intended for the IOB.
//     The inter-packet gap is checked at every frame start.
//   - Saturating statistics counters are read through a registered select port.
//   - Three activity LEDs are each stretched by a down-counter.
//
// Ports
//   gtx_clk      125 MHz clock for all logic
//   rst_n        asynchronous active-low reset
//   gmii_rxd     GMII receive data
//   gmii_rx_dv   GMII receive data valid
//   gmii_rx_er   GMII receive error
//   gmii_txd     GMII transmit data
//   gmii_tx_en   GMII transmit enable
//   gmii_tx_er   GMII transmit error, tied low
//   abst_in      Rx data to the aggregator
//   abst_in_s    Rx strobe to the aggregator
//   abst_out     Tx data from the aggregator
//   abst_out_s   Tx strobe from the aggregator
//   cnt_sel      0 rx_frames, 1 rx_err_frames, 2 tx_frames, 3 tx_ipg_viol
//   cnt_clr      single-cycle pulse that clears all counters
//   cnt_data     selected counter, registered
//   status       {err_led, tx_led, rx_led}
module ether_gmii_port #(
  parameter int TX_PIPE = 1,
  parameter int IPG_MIN = 12,
  parameter int CNT_W   = 16,
  parameter int LED_W   = 22
) (
  input  logic             gtx_clk,
  input  logic             rst_n,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,
  output logic [7:0]       abst_in,
  output logic             abst_in_s,
  input  logic [7:0]       abst_out,
  input  logic             abst_out_s,
  input  logic [1:0]       cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_data,
  output logic [2:0]       status
);

  localparam int GAP_W = $clog2(IPG_MIN + 1);
  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(IPG_MIN);

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_PASS   = 2'd1,
    RX_POISON = 2'd2
  } rx_state_e;

  // ---------------------------------------------------------------- Rx path
  rx_state_e  rx_state_q, rx_state_d;
  logic       rx_armed_q, rx_armed_d;
  logic [7:0] abst_in_q, abst_in_d;
  logic       abst_in_s_q, abst_in_s_d;
  logic       rx_frame_ev;
  logic       rx_err_ev;

  // The Rx path arms on the first idle cycle after reset. This keeps a
  // frame that is already in progress at reset release out of the FSM.
  // A byte that carries rx_er is itself suppressed, so the output
  // strobe falls on that byte and not one byte later.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_armed_d  = rx_armed_q | ~gmii_rx_dv;
    abst_in_d   = 8'd0;
    abst_in_s_d = 1'b0;
    rx_frame_ev = 1'b0;
    rx_err_ev   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_armed_q && gmii_rx_dv) begin
          rx_frame_ev = 1'b1;
          if (gmii_rx_er) begin
            rx_err_ev  = 1'b1;
            rx_state_d = RX_POISON;
          end else begin
            rx_state_d  = RX_PASS;
            abst_in_d   = gmii_rxd;
            abst_in_s_d = 1'b1;
          end
        end
      end
      RX_PASS: begin
        if (!gmii_rx_dv) begin
          rx_state_d = RX_IDLE;
        end else if (gmii_rx_er) begin
          rx_err_ev  = 1'b1;
          rx_state_d = RX_POISON;
        end else begin
          abst_in_d   = gmii_rxd;
          abst_in_s_d = 1'b1;
        end
      end
      RX_POISON: begin
        if (!gmii_rx_dv) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge gtx_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      rx_armed_q  <= 1'b0;
      abst_in_q   <= 8'd0;
      abst_in_s_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_armed_q  <= rx_armed_d;
      abst_in_q   <= abst_in_d;
      abst_in_s_q <= abst_in_s_d;
    end
  end

  assign abst_in   = abst_in_q;
  assign abst_in_s = abst_in_s_q;

  // ---------------------------------------------------------------- Tx path
  logic             tx_armed_q, tx_armed_d;
  logic             tx_prev_s_q, tx_prev_s_d;
  logic [GAP_W-1:0] tx_gap_q, tx_gap_d;
  logic [8:0]       tx_pipe_q [TX_PIPE];
  logic [8:0]       tx_pipe_d [TX_PIPE];
  logic             tx_frame_ev;
  logic             tx_viol_ev;

  // The gap counter jumps straight to saturation on the arming cycle.
  // This means the first frame after reset is never flagged. A short gap
  // is only counted; the frame itself still goes out unchanged.
  always_comb begin
    tx_armed_d  = tx_armed_q | ~abst_out_s;
    tx_prev_s_d = abst_out_s;
    tx_frame_ev = tx_armed_q & abst_out_s & ~tx_prev_s_q;
    tx_viol_ev  = tx_frame_ev & (tx_gap_q < GAP_SAT);
    tx_gap_d    = tx_gap_q;
    if (abst_out_s) begin
      tx_gap_d = '0;
    end else if (!tx_armed_q) begin
      tx_gap_d = GAP_SAT;
    end else if (tx_gap_q != GAP_SAT) begin
      tx_gap_d = tx_gap_q + GAP_W'(1);
    end
    for (int i = 0; i < TX_PIPE; i++) begin
      tx_pipe_d[i] = 9'd0;
    end
    tx_pipe_d[0] = tx_armed_q ? {abst_out_s, abst_out} : 9'd0;
    for (int i = 1; i < TX_PIPE; i++) begin
      tx_pipe_d[i] = tx_pipe_q[i-1];
    end
  end

  always_ff @(posedge gtx_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_armed_q  <= 1'b0;
      tx_prev_s_q <= 1'b0;
      tx_gap_q    <= '0;
      for (int i = 0; i < TX_PIPE; i++) begin
        tx_pipe_q[i] <= 9'd0;
      end
    end else begin
      tx_armed_q  <= tx_armed_d;
      tx_prev_s_q <= tx_prev_s_d;
      tx_gap_q    <= tx_gap_d;
      for (int i = 0; i < TX_PIPE; i++) begin
        tx_pipe_q[i] <= tx_pipe_d[i];
      end
    end
  end

  assign gmii_txd   = tx_pipe_q[TX_PIPE-1][7:0];
  assign gmii_tx_en = tx_pipe_q[TX_PIPE-1][8];
  assign gmii_tx_er = 1'b0;

  // ---------------------------------------------------------- Statistics
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_data_q, cnt_data_d;

  // A clear wins over a same-cycle event, and that event is lost.
  // The read port samples the counter before this cycle's update.
  always_comb begin
    cnt_inc    = {tx_viol_ev, tx_frame_ev, rx_err_ev, rx_frame_ev};
    cnt_data_d = cnt_q[cnt_sel];
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (cnt_inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge gtx_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_data_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_data_q <= cnt_data_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cnt_data = cnt_data_q;

  // ---------------------------------------------------------------- LEDs
  logic [LED_W-1:0] led_q [3];
  logic [LED_W-1:0] led_d [3];
  logic [2:0]       led_ev;

  // On each event the stretch counter reloads to full and then counts
  // down. An LED is lit while its counter is non-zero.
  always_comb begin
    led_ev = {rx_err_ev | tx_viol_ev, tx_frame_ev, rx_frame_ev};
    for (int i = 0; i < 3; i++) begin
      led_d[i] = led_q[i];
      if (led_ev[i]) begin
        led_d[i] = {LED_W{1'b1}};
      end else if (led_q[i] != '0) begin
        led_d[i] = led_q[i] - LED_W'(1);
      end
    end
  end

  always_ff @(posedge gtx_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        led_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        led_q[i] <= led_d[i];
      end
    end
  end

  assign status = {led_q[2] != '0, led_q[1] != '0, led_q[0] != '0};

endmodule

// File: tb/tb_ether_gmii_port.sv
// tb_ether_gmii_port
//   Directed and randomized bench for ether_gmii_port. The bench uses
//   TX_PIPE=3, IPG_MIN=12, CNT_W=4 and LED_W=4.
//   Expected behaviour comes from a frame-level reference model:
//   - Rx bytes pass when they come before the first errored byte of a frame.
//   - Tx output is the armed input history delayed by TX_PIPE cycles.
//   - Each counter is a saturating event tally.
//   - Each LED is lit within a fixed window after its last event.
module tb_ether_gmii_port;

  localparam int TX_PIPE = 3;
  localparam int IPG_MIN = 12;
  localparam int CNT_W   = 4;
  localparam int LED_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int LED_LEN = (1 << LED_W) - 1;

  logic             gtx_clk;
  logic             rst_n;
  logic [7:0]       gmii_rxd;
  logic             gmii_rx_dv;
  logic             gmii_rx_er;
  logic [7:0]       gmii_txd;
  logic             gmii_tx_en;
  logic             gmii_tx_er;
  logic [7:0]       abst_in;
  logic             abst_in_s;
  logic [7:0]       abst_out;
  logic             abst_out_s;
  logic [1:0]       cnt_sel;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_data;
  logic [2:0]       status;

  ether_gmii_port #(
    .TX_PIPE(TX_PIPE),
    .IPG_MIN(IPG_MIN),
    .CNT_W  (CNT_W),
    .LED_W  (LED_W)
  ) dut (
    .gtx_clk   (gtx_clk),
    .rst_n     (rst_n),
    .gmii_rxd  (gmii_rxd),
    .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er),
    .gmii_txd  (gmii_txd),
    .gmii_tx_en(gmii_tx_en),
    .gmii_tx_er(gmii_tx_er),
    .abst_in   (abst_in),
    .abst_in_s (abst_in_s),
    .abst_out  (abst_out),
    .abst_out_s(abst_out_s),
    .cnt_sel   (cnt_sel),
    .cnt_clr   (cnt_clr),
    .cnt_data  (cnt_data),
    .status    (status)
  );

  // 125 MHz-style free-running clock
  initial gtx_clk = 1'b0;
  always #4 gtx_clk = ~gtx_clk;

  // Scoreboard and reference model state
  int         checks = 0;
  int         passes = 0;
  logic [8:0] tx_hist [$];
  bit         tx_armed_m;
  bit         tx_prev_s_m;
  int         idle_run_m;
  int         exp_cnt [4];
  int         last_ev [3];
  int         cyc;
  int         rx_strobe_cycles;
  int         rx_led_cycles;
  bit         err_led_seen;

  // Hard time limit so that the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Single comparison point: counts, asserts and reports one value
  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge gtx_clk);
    #1;
  endtask

  // Model state after reset: pipeline empty, both paths unarmed, no events
  task automatic resetModel;
    tx_hist.delete();
    for (int i = 0; i < TX_PIPE - 1; i++) tx_hist.push_back(9'd0);
    tx_armed_m  = 1'b0;
    tx_prev_s_m = 1'b0;
    idle_run_m  = 0;
    cyc         = 0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    for (int i = 0; i < 3; i++) last_ev[i] = -1000;
  endtask

  task automatic bump(input int idx, input bit ev);
    if (ev) exp_cnt[idx] = (exp_cnt[idx] < CNT_MAX) ? exp_cnt[idx] + 1 : CNT_MAX;
  endtask

  // Compare every output against the model after the clock edge
  task automatic checkOutput(input logic exp_rs, input logic chk_rd, input logic [7:0] exp_rd,
                             input int exp_cd);
    logic [8:0] txv;
    logic [2:0] exp_st;
    txv = tx_hist[tx_hist.size() - TX_PIPE];
    for (int j = 0; j < 3; j++) begin
      exp_st[j] = ((cyc - last_ev[j]) >= 0) && ((cyc - last_ev[j]) <= LED_LEN - 1);
    end
    checkEq("abst_in_s", 32'(abst_in_s), 32'(exp_rs));
    if (chk_rd) checkEq("abst_in", 32'(abst_in), 32'(exp_rd));
    checkEq("gmii_tx_en", 32'(gmii_tx_en), 32'(txv[8]));
    checkEq("gmii_txd", 32'(gmii_txd), 32'(txv[7:0]));
    checkEq("gmii_tx_er", 32'(gmii_tx_er), 32'd0);
    checkEq("cnt_data", 32'(cnt_data), exp_cd);
    checkEq("status", 32'(status), 32'(exp_st));
    if (abst_in_s) rx_strobe_cycles++;
    if (status[0]) rx_led_cycles++;
    if (status[2]) err_led_seen = 1'b1;
    while (tx_hist.size() > 8) void'(tx_hist.pop_front());
  endtask

  // Drive one cycle of inputs, advance the model, clock and check
  task automatic applyStimulus(input logic dv, input logic er, input logic [7:0] rxd,
                               input logic ts, input logic [7:0] td,
                               input logic rx_start, input logic rx_err,
                               input logic exp_rs, input logic chk_rd, input logic [7:0] exp_rd);
    bit tx_start;
    bit tx_viol;
    int exp_cd;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    gmii_rxd   = rxd;
    abst_out_s = ts;
    abst_out   = td;
    exp_cd     = exp_cnt[cnt_sel];
    tx_hist.push_back(tx_armed_m ? {ts, td} : 9'd0);
    tx_start = tx_armed_m && ts && !tx_prev_s_m;
    tx_viol  = tx_start && (idle_run_m < IPG_MIN);
    if (!ts) idle_run_m = tx_armed_m ? idle_run_m + 1 : 1000000;
    else     idle_run_m = 0;
    if (!ts) tx_armed_m = 1'b1;
    tx_prev_s_m = ts;
    if (cnt_clr) begin
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    end else begin
      bump(0, rx_start);
      bump(1, rx_err);
      bump(2, tx_start);
      bump(3, tx_viol);
    end
    if (rx_start) last_ev[0] = cyc;
    if (tx_start) last_ev[1] = cyc;
    if (rx_err || tx_viol) last_ev[2] = cyc;
    tick;
    checkOutput(exp_rs, chk_rd, exp_rd, exp_cd);
    cnt_clr = 1'b0;
    cyc++;
  endtask

  // Idle on both paths; rx_er toggles randomly with rx_dv low and is ignored
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 8'($urandom),
                    1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
  endtask

  // Rx frame of len bytes; err_idx is the first errored byte (-1 for none).
  // Bytes before err_idx are delivered; the rest are suppressed as zero.
  task automatic rxFrame(input int len, input int err_idx, input int gap);
    logic [7:0] b;
    bit er;
    bit pass;
    for (int i = 0; i < len; i++) begin
      b    = 8'($urandom);
      er   = (err_idx >= 0) && ((i == err_idx) || ((i > err_idx) && ($urandom_range(0, 3) == 0)));
      pass = (err_idx < 0) || (i < err_idx);
      applyStimulus(1'b1, er, b, 1'b0, 8'($urandom), i == 0, i == err_idx,
                    pass, 1'b1, pass ? b : 8'h00);
    end
    idleCycles(gap);
  endtask

  // Tx frame preceded by exactly gap idle cycles
  task automatic txFrame(input int gap, input int len);
    idleCycles(gap);
    for (int i = 0; i < len; i++) begin
      applyStimulus(1'b0, 1'b0, 8'($urandom), 1'b1, 8'($urandom),
                    1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
  endtask

  task automatic readCounter(input logic [1:0] sel, input int exp, input string tag);
    cnt_sel = sel;
    idleCycles(1);
    checkEq(tag, 32'(cnt_data), exp);
  endtask

  // Main directed sequence followed by randomized traffic
  initial begin
    int len;
    int err;
    rst_n      = 1'b0;
    gmii_rx_dv = 1'b1;
    gmii_rx_er = 1'b0;
    gmii_rxd   = 8'h33;
    abst_out_s = 1'b1;
    abst_out   = 8'h5a;
    cnt_sel    = 2'd0;
    cnt_clr    = 1'b0;
    rx_strobe_cycles = 0;
    rx_led_cycles    = 0;
    err_led_seen     = 1'b0;
    repeat (3) tick;
    checkEq("reset_abst_in_s", 32'(abst_in_s), 32'd0);
    checkEq("reset_abst_in", 32'(abst_in), 32'd0);
    checkEq("reset_tx_en", 32'(gmii_tx_en), 32'd0);
    checkEq("reset_txd", 32'(gmii_txd), 32'd0);
    checkEq("reset_cnt_data", 32'(cnt_data), 32'd0);
    checkEq("reset_status", 32'(status), 32'd0);
    resetModel();
    rst_n = 1'b1;

    // Rx frame and Tx burst already in flight at reset release are dropped
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0, 8'($urandom), 1'(i < 5), 8'($urandom),
                    1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
    checkEq("discard_strobe_cycles", rx_strobe_cycles, 0);
    idleCycles(4);
    readCounter(2'd0, 0, "rx_frames_after_discard");
    readCounter(2'd2, 0, "tx_frames_after_discard");

    // Clean 64-byte frame
    rx_strobe_cycles = 0;
    rxFrame(64, -1, 4);
    checkEq("rx64_strobe_cycles", rx_strobe_cycles, 64);
    readCounter(2'd0, 1, "rx_frames_one");

    // 72-byte frame with rx_er on the 20th byte
    rx_strobe_cycles = 0;
    err_led_seen     = 1'b0;
    rxFrame(72, 19, 4);
    checkEq("rx72_strobe_cycles", rx_strobe_cycles, 19);
    checkEq("err_led_seen", 32'(err_led_seen), 32'd1);
    readCounter(2'd0, 2, "rx_frames_two");
    readCounter(2'd1, 1, "rx_err_frames_one");

    // Error on the very first byte counts in both counters
    rxFrame(10, 0, 4);
    readCounter(2'd0, 3, "rx_frames_three");
    readCounter(2'd1, 2, "rx_err_frames_two");

    // Tx frames with idle gaps of 20, 8 and 12 cycles
    txFrame(20, 64);
    txFrame(8, 64);
    txFrame(12, 64);
    idleCycles(TX_PIPE + 2);
    readCounter(2'd2, 3, "tx_frames_three");
    readCounter(2'd3, 1, "tx_ipg_viol_one");

    // LED stretch: single start, then a retrigger ten cycles after the first
    idleCycles(20);
    rx_led_cycles = 0;
    rxFrame(3, -1, 37);
    checkEq("rx_led_single", rx_led_cycles, LED_LEN);
    rx_led_cycles = 0;
    rxFrame(3, -1, 7);
    rxFrame(3, -1, 40);
    checkEq("rx_led_retrigger", rx_led_cycles, 10 + LED_LEN);

    // Clear coinciding with a frame start drops that frame's count
    cnt_sel = 2'd0;
    cnt_clr = 1'b1;
    rxFrame(5, -1, 3);
    readCounter(2'd0, 0, "rx_frames_after_clr");
    readCounter(2'd3, 0, "tx_ipg_viol_after_clr");

    // Random Rx frames drive rx_frames into saturation
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(4, 40);
      err = (($urandom_range(0, 3) == 0) && (exp_cnt[1] < 12)) ? $urandom_range(0, len - 1) : -1;
      rxFrame(len, err, $urandom_range(1, 6));
    end
    readCounter(2'd0, CNT_MAX, "rx_frames_saturated");
    readCounter(2'd1, exp_cnt[1], "rx_err_frames_random");

    // Random Tx frames with gaps around IPG_MIN
    for (int f = 0; f < 10; f++) begin
      txFrame($urandom_range(1, 20), $urandom_range(2, 30));
    end
    idleCycles(TX_PIPE + 2);
    readCounter(2'd2, exp_cnt[2], "tx_frames_random");
    readCounter(2'd3, exp_cnt[3], "tx_ipg_viol_random");

    idleCycles(LED_LEN + 5);
    checkEq("leds_off", 32'(status), 32'd0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
